// File: rtl/tlb_cam_pkg.sv
// Shared TLB field layout, probe-fail bit, legal page masks and entry record.
// Consumers: tlb_cam, tlb_entry_match (optional ASID match: TLB_ASID_MATCH_EN).
package tlb_cam_pkg;

  localparam int unsigned HI_VPN2_LSB    = 13;
  localparam int unsigned LO_PFN_LSB     = 6;
  localparam int unsigned PM_MASK_LSB    = 13;
  localparam int unsigned PROBE_FAIL_BIT = 31;

  localparam logic [11:0] MASK_4K   = 12'h000;
  localparam logic [11:0] MASK_16K  = 12'h003;
  localparam logic [11:0] MASK_64K  = 12'h00f;
  localparam logic [11:0] MASK_256K = 12'h03f;
  localparam logic [11:0] MASK_1M   = 12'h0ff;
  localparam logic [11:0] MASK_4M   = 12'h3ff;
  localparam logic [11:0] MASK_16M  = 12'hfff;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic [11:0] mask;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  function automatic logic [3:0] mask_ones(input logic [11:0] m);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 12; i++) n = n + {3'b000, m[i]};
    return n;
  endfunction

  function automatic logic [31:0] pack_lo(input logic [19:0] pfn, input logic [2:0] c,
                                          input logic d, input logic v, input logic g);
    return {6'b0, pfn, c, d, v, g};
  endfunction

endpackage

// File: rtl/tlb_cam_if.sv
// MMU <-> TLB bus: lookup, probe, TLBWI/TLBWR write and TLBR read signals.
interface tlb_cam_if;
  logic [31:0] vAddr;
  logic [31:0] pAddr;
  logic [31:0] entryHiIn;
  logic [31:0] entryLo0In;
  logic [31:0] entryLo1In;
  logic [31:0] pageMaskIn;
  logic [31:0] index;
  logic        we;
  logic        re;
  logic        found;
  logic        bitV;
  logic        bitD;
  logic [31:0] entryHiOut;
  logic [31:0] entryLo0Out;
  logic [31:0] entryLo1Out;
  logic [31:0] pageMaskOut;
  logic [31:0] matchedIndex;

  modport master (
    output vAddr, entryHiIn, entryLo0In, entryLo1In, pageMaskIn, index, we, re,
    input  pAddr, found, bitV, bitD, entryHiOut, entryLo0Out, entryLo1Out,
           pageMaskOut, matchedIndex
  );

  modport slave (
    input  vAddr, entryHiIn, entryLo0In, entryLo1In, pageMaskIn, index, we, re,
    output pAddr, found, bitV, bitD, entryHiOut, entryLo0Out, entryLo1Out,
           pageMaskOut, matchedIndex
  );
endinterface

// File: rtl/tlb_cam_entry_match.sv
// Per-entry comparator: VPN2/ASID hit and even/odd half select.
// With TLB_ASID_MATCH_EN undefined every entry behaves as global.
module tlb_entry_match
  import tlb_cam_pkg::*;
(
  input  logic [18:0] vpn2,
  input  logic [11:0] mask,
  input  logic [7:0]  asid,
  input  logic        g,
  input  logic [31:0] vaddr,
  input  logic [7:0]  cur_asid,
  output logic        hit,
  output logic        odd
);

  logic       vpn_eq;
  logic       asid_ok;
  logic [4:0] sel;

`ifdef TLB_ASID_MATCH_EN
  assign asid_ok = g | (asid == cur_asid);
`else
  logic unused_asid;
  assign unused_asid = ^{g, asid, cur_asid};
  assign asid_ok     = 1'b1;
`endif

  always_comb begin
    vpn_eq = ((vaddr[31:HI_VPN2_LSB] ^ vpn2) & ~{7'b0, mask}) == '0;
    hit    = vpn_eq & asid_ok;
    sel    = 5'd12 + {1'b0, mask_ones(mask)};
    odd    = vaddr[sel];
  end

endmodule

// File: rtl/tlb_cam.sv
// Fully associative joint TLB: entry storage, lowest-index priority encode, output mux.
// Optional ASID matching via TLB_ASID_MATCH_EN (undefined: all entries global).
module tlb_cam
  import tlb_cam_pkg::*;
#(
  parameter int unsigned ENTRY_ADDR_WIDTH = 4
) (
  input logic       clk,
  input logic       res,
  tlb_cam_if.slave  bus
);

  localparam int unsigned ENTRY_COUNT = 1 << ENTRY_ADDR_WIDTH;

  tlb_entry_t                  tlb [ENTRY_COUNT];
  tlb_entry_t                  new_e;
  tlb_entry_t                  rd_e;
  tlb_entry_t                  sel_e;
  logic [ENTRY_COUNT-1:0]      hit;
  logic [ENTRY_COUNT-1:0]      odd;
  logic [ENTRY_ADDR_WIDTH-1:0] acc_idx;
  logic [ENTRY_ADDR_WIDTH-1:0] hit_idx;
  logic                        found_w;
  logic                        sel_odd;
  logic [19:0]                 sel_pfn;
  logic [31:0]                 om;
  logic [31:0]                 mi;
  logic [31:0]                 hi_q, lo0_q, lo1_q, pm_q;
  logic                        unused_bits;

  assign acc_idx     = bus.index[ENTRY_ADDR_WIDTH-1:0];
  assign unused_bits = ^{bus.index[31:ENTRY_ADDR_WIDTH], bus.entryHiIn[12:8],
                         bus.entryLo0In[31:26], bus.entryLo1In[31:26],
                         bus.pageMaskIn[31:25], bus.pageMaskIn[12:0]};

  always_comb begin
    new_e      = '0;
    new_e.vpn2 = bus.entryHiIn[31:HI_VPN2_LSB];
    new_e.asid = bus.entryHiIn[7:0];
    new_e.mask = bus.pageMaskIn[24:PM_MASK_LSB];
    new_e.g    = bus.entryLo0In[0] & bus.entryLo1In[0];
    new_e.pfn0 = bus.entryLo0In[25:LO_PFN_LSB];
    new_e.c0   = bus.entryLo0In[5:3];
    new_e.d0   = bus.entryLo0In[2];
    new_e.v0   = bus.entryLo0In[1];
    new_e.pfn1 = bus.entryLo1In[25:LO_PFN_LSB];
    new_e.c1   = bus.entryLo1In[5:3];
    new_e.d1   = bus.entryLo1In[2];
    new_e.v1   = bus.entryLo1In[1];
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int unsigned i = 0; i < ENTRY_COUNT; i++) tlb[i] <= '0;
    end else if (bus.we) begin
      tlb[acc_idx] <= new_e;
    end
  end

  for (genvar i = 0; i < ENTRY_COUNT; i++) begin : g_match
    tlb_entry_match u_match (
      .vpn2     (tlb[i].vpn2),
      .mask     (tlb[i].mask),
      .asid     (tlb[i].asid),
      .g        (tlb[i].g),
      .vaddr    (bus.vAddr),
      .cur_asid (bus.entryHiIn[7:0]),
      .hit      (hit[i]),
      .odd      (odd[i])
    );
  end

  always_comb begin
    found_w = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < ENTRY_COUNT; i++) begin
      if (hit[i] && !found_w) begin
        found_w = 1'b1;
        hit_idx = ENTRY_ADDR_WIDTH'(i);
      end
    end
  end

  // Offset spans 12+k bits for a 4K<<k half page, so MASK sits directly above 12'hfff.
  always_comb begin
    sel_e   = tlb[hit_idx];
    sel_odd = odd[hit_idx];
    sel_pfn = sel_odd ? sel_e.pfn1 : sel_e.pfn0;
    om      = {8'b0, sel_e.mask, 12'hfff};
    mi      = '0;
    mi[PROBE_FAIL_BIT] = ~found_w;
    bus.found = found_w;
    bus.pAddr = '0;
    bus.bitV  = 1'b0;
    bus.bitD  = 1'b0;
    if (found_w) begin
      mi[ENTRY_ADDR_WIDTH-1:0] = hit_idx;
      bus.pAddr = ({sel_pfn, 12'b0} & ~om) | (bus.vAddr & om);
      bus.bitV  = sel_odd ? sel_e.v1 : sel_e.v0;
      bus.bitD  = sel_odd ? sel_e.d1 : sel_e.d0;
    end
    bus.matchedIndex = mi;
  end

  assign rd_e = tlb[acc_idx];

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      hi_q  <= '0;
      lo0_q <= '0;
      lo1_q <= '0;
      pm_q  <= '0;
    end else if (bus.re) begin
      hi_q  <= {rd_e.vpn2 & ~{7'b0, rd_e.mask}, 5'b0, rd_e.asid};
      lo0_q <= pack_lo(rd_e.pfn0, rd_e.c0, rd_e.d0, rd_e.v0, rd_e.g);
      lo1_q <= pack_lo(rd_e.pfn1, rd_e.c1, rd_e.d1, rd_e.v1, rd_e.g);
      pm_q  <= {7'b0, rd_e.mask, 13'b0};
    end
  end

  assign bus.entryHiOut  = hi_q;
  assign bus.entryLo0Out = lo0_q;
  assign bus.entryLo1Out = lo1_q;
  assign bus.pageMaskOut = pm_q;

endmodule

// File: tb/tb_tlb_cam.sv
// Directed bench for tlb_cam: table of lookups plus read/write/reset sequences.
module tb_tlb_cam;

  logic clk;
  logic res;
  tlb_cam_if bus();

  tlb_cam #(.ENTRY_ADDR_WIDTH(4)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_pass;
  int unsigned n_total;

  typedef struct {
    logic [31:0] vaddr;
    logic [31:0] hi;
    logic        found;
    logic [31:0] paddr;
    logic        v;
    logic        d;
    logic [31:0] midx;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic write_entry(input logic [31:0] idx, input logic [31:0] hi,
                             input logic [31:0] lo0, input logic [31:0] lo1,
                             input logic [31:0] pm);
    @(negedge clk);
    bus.index = idx; bus.entryHiIn = hi; bus.entryLo0In = lo0;
    bus.entryLo1In = lo1; bus.pageMaskIn = pm; bus.we = 1'b1;
    @(negedge clk);
    bus.we = 1'b0;
  endtask

  task automatic read_entry(input logic [31:0] idx);
    @(negedge clk);
    bus.index = idx; bus.re = 1'b1;
    @(negedge clk);
    bus.re = 1'b0;
  endtask

  task automatic check_outs(input string name, input logic [31:0] hi, input logic [31:0] lo0,
                            input logic [31:0] lo1, input logic [31:0] pm);
    chk({name, ".hi"},  bus.entryHiOut,  hi);
    chk({name, ".lo0"}, bus.entryLo0Out, lo0);
    chk({name, ".lo1"}, bus.entryLo1Out, lo1);
    chk({name, ".pm"},  bus.pageMaskOut, pm);
  endtask

  task automatic lookup(input string name, input vec_t t);
    @(negedge clk);
    bus.vAddr = t.vaddr; bus.entryHiIn = t.hi;
    #2;
    chk({name, ".found"}, {31'b0, bus.found}, {31'b0, t.found});
    chk({name, ".paddr"}, bus.pAddr, t.paddr);
    chk({name, ".v"},     {31'b0, bus.bitV}, {31'b0, t.v});
    chk({name, ".d"},     {31'b0, bus.bitD}, {31'b0, t.d});
    chk({name, ".midx"},  bus.matchedIndex, t.midx);
  endtask

  initial begin
    vec_t h;
    n_pass = 0; n_total = 0;
    res = 1'b0;
    bus.vAddr = '0; bus.entryHiIn = '0; bus.entryLo0In = '0; bus.entryLo1In = '0;
    bus.pageMaskIn = '0; bus.index = '0; bus.we = 1'b0; bus.re = 1'b0;

    // Lookup table (entries written below before it is applied)
    vt[0] = '{32'h0040_0ABC, 32'h0000_0005, 1'b1, 32'h0010_0ABC, 1'b1, 1'b1, 32'd2};
    vt[1] = '{32'h0040_1123, 32'h0000_0005, 1'b1, 32'h0020_0123, 1'b1, 1'b0, 32'd2};
`ifdef TLB_ASID_MATCH_EN
    vt[2] = '{32'h0040_0ABC, 32'h0000_0006, 1'b0, 32'h0,         1'b0, 1'b0, 32'h8000_0000};
`else
    vt[2] = '{32'h0040_0ABC, 32'h0000_0006, 1'b1, 32'h0010_0ABC, 1'b1, 1'b1, 32'd2};
`endif
    vt[3] = '{32'h0080_2345, 32'h0000_0006, 1'b1, 32'h0040_2345, 1'b1, 1'b0, 32'd7};
    vt[4] = '{32'h0080_6345, 32'h0000_0006, 1'b1, 32'h0050_2345, 1'b1, 1'b1, 32'd7};
    vt[5] = '{32'h0100_0010, 32'h0000_0006, 1'b1, 32'h0011_1010, 1'b1, 1'b0, 32'd4};
    vt[6] = '{32'h0100_1010, 32'h0000_0006, 1'b1, 32'h0022_2010, 1'b1, 1'b1, 32'd4};
    vt[7] = '{32'h0700_0000, 32'h0000_0006, 1'b0, 32'h0,         1'b0, 1'b0, 32'h8000_0000};
    vt[8] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0,         1'b0, 1'b0, 32'd0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    res = 1'b1;

    // Reset state
    check_outs("rst", 32'h0, 32'h0, 32'h0, 32'h0);
    read_entry(32'd3);
    check_outs("rd3_rst", 32'h0, 32'h0, 32'h0, 32'h0);
    lookup("rst_lookup0", '{32'h0000_0000, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 32'd0});

    // Populate: idx2 4K non-global, idx7 16K, idx4/idx9 duplicate VPN2
    write_entry(32'd2, 32'h0040_0005, 32'h0000_4006, 32'h0000_8002, 32'h0);
    write_entry(32'd7, 32'h0080_6006, 32'h0001_0003, 32'h0001_4007, 32'h0000_6000);
    write_entry(32'd4, 32'h0100_0006, 32'h0000_4443, 32'h0000_8887, 32'h0);
    write_entry(32'd9, 32'h0100_0006, 32'h0002_6643, 32'h0002_6643, 32'h0);

    for (int i = 0; i < 9; i++) lookup($sformatf("lookup%0d", i), vt[i]);

    // Global bit set on both halves overrides ASID mismatch
    write_entry(32'd2, 32'h0040_0005, 32'h0000_4007, 32'h0000_8003, 32'h0);
    lookup("global", '{32'h0040_0ABC, 32'h0000_0006, 1'b1, 32'h0010_0ABC, 1'b1, 1'b1, 32'd2});

    // Readback masks VPN2 by MASK
    read_entry(32'd7);
    check_outs("rd7", 32'h0080_0006, 32'h0001_0003, 32'h0001_4007, 32'h0000_6000);

    // G stored as AND of both halves
    write_entry(32'd11, 32'h0300_0006, 32'h0000_4007, 32'h0000_8002, 32'h0);
    read_entry(32'd11);
    check_outs("rd11", 32'h0300_0006, 32'h0000_4006, 32'h0000_8002, 32'h0);

    // Out regs hold with re=0
    @(negedge clk);
    bus.index = 32'd2;
    @(negedge clk);
    check_outs("hold", 32'h0300_0006, 32'h0000_4006, 32'h0000_8002, 32'h0);

    // Simultaneous write and read of idx4 returns old contents
    @(negedge clk);
    bus.index = 32'd4; bus.entryHiIn = 32'h0200_0006; bus.entryLo0In = 32'h0001_0002;
    bus.entryLo1In = 32'h0001_0003; bus.pageMaskIn = 32'h0; bus.we = 1'b1; bus.re = 1'b1;
    @(negedge clk);
    bus.we = 1'b0; bus.re = 1'b0;
    check_outs("wr_rd4", 32'h0100_0006, 32'h0000_4443, 32'h0000_8887, 32'h0);
    lookup("dup_after", '{32'h0100_0010, 32'h0000_0006, 1'b1, 32'h0099_9010, 1'b1, 1'b0, 32'd9});
    lookup("new4", '{32'h0200_0010, 32'h0000_0006, 1'b1, 32'h0040_0010, 1'b1, 1'b0, 32'd4});

    // Reset asserted during a write cycle
    @(negedge clk);
    bus.index = 32'd5; bus.entryHiIn = 32'h0500_0006; bus.entryLo0In = 32'h0000_4007;
    bus.entryLo1In = 32'h0000_4007; bus.pageMaskIn = 32'h0; bus.we = 1'b1;
    #2 res = 1'b0;
    #1 check_outs("async_rst", 32'h0, 32'h0, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    bus.we = 1'b0;
    #1 res = 1'b1;
    h = '{32'h0500_0010, 32'h0000_0006, 1'b0, 32'h0, 1'b0, 1'b0, 32'h8000_0000};
    lookup("rst_wr5", h);
    h.vaddr = 32'h0100_0010;
    lookup("rst_wr9", h);
    read_entry(32'd5);
    check_outs("rd5_rst", 32'h0, 32'h0, 32'h0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
